lcd_rx_capture: RTL and testbench

LCD_RX_CAPTURE -- requirements
Module: lcd_rx_capture

---
 rtl/lcd_rx_capture.sv | 247 ++++++++++++++++++++++++
 tb/tb_lcd_rx_capture.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rx_capture.sv
// lcd_rx_capture: samples a parallel RGB LCD bus (NCLK/HD/VD/DEN/RGB) in the
// CLK domain, emits one PIX_VALID pulse per active pixel with its coordinates,
// and reports per-frame geometry plus a lock/error status.
// Optional build macro: LCD_RX_CAPTURE_SUM_EN adds FRAME_SUM, the mod-2^16
// sum of R+G+B over every emitted pixel of the closed frame.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// SEEK      | waiting for the first VD falling edge; DEN is ignored
// LINE_WAIT | inside a frame, between lines (DEN low)
// LINE_ACT  | inside an active line, capturing pixels while DEN is high

module lcd_rx_capture #(
  parameter int H_ACT = 800,
  parameter int V_ACT = 480
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        NCLK,
  input  logic        HD,
  input  logic        VD,
  input  logic        DEN,
  input  logic [7:0]  R,
  input  logic [7:0]  G,
  input  logic [7:0]  B,
  output logic        PIX_VALID,
  output logic [10:0] PIX_X,
  output logic [9:0]  PIX_Y,
  output logic [23:0] PIX_RGB,
  output logic        FRAME_DONE,
  output logic [10:0] FRAME_W,
  output logic [9:0]  FRAME_H,
  output logic        LINE_ERR,
  output logic        SYNC_LOCK
`ifdef LCD_RX_CAPTURE_SUM_EN
  ,
  output logic [15:0] FRAME_SUM
`endif
);

  localparam logic [10:0] H_ACT_W = 11'(H_ACT);
  localparam logic [9:0]  V_ACT_H = 10'(V_ACT);
  localparam logic [10:0] X_MAX   = 11'h7FF;
  localparam logic [9:0]  Y_MAX   = 10'h3FF;

  typedef enum logic [1:0] {SEEK, LINE_WAIT, LINE_ACT} state_t;

  state_t      state, state_nx;
  logic        s1_nclk, s1_hd, s1_vd, s1_den;
  logic [23:0] s1_rgb;
  logic        s2_nclk, s2_hd, s2_vd;
  logic        tick, vd_fall, hd_fall;

  logic [10:0] x, x_nx, last_w, last_w_nx, cap_x;
  logic [9:0]  y, y_nx, y_line;
  logic        err_frame, err_frame_nx, line_err_nx;
  logic        pix_valid_nx, frame_done_nx, sync_lock_nx;
  logic [10:0] pix_x_nx, frame_w_nx;
  logic [9:0]  pix_y_nx, frame_h_nx;
  logic [23:0] pix_rgb_nx;
  logic        cap, close_line, close_frame, err_hit;

  // Bus is sampled once (S1) and NCLK/HD/VD again (S2) for edge detection;
  // protocol decisions only use the S1 copy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_nclk <= 1'b0;
      s1_hd   <= 1'b0;
      s1_vd   <= 1'b0;
      s1_den  <= 1'b0;
      s1_rgb  <= '0;
      s2_nclk <= 1'b0;
      s2_hd   <= 1'b0;
      s2_vd   <= 1'b0;
    end else begin
      s1_nclk <= NCLK;
      s1_hd   <= HD;
      s1_vd   <= VD;
      s1_den  <= DEN;
      s1_rgb  <= {R, G, B};
      s2_nclk <= s1_nclk;
      s2_hd   <= s1_hd;
      s2_vd   <= s1_vd;
    end
  end

  assign tick    = s1_nclk & ~s2_nclk;
  assign vd_fall = ~s1_vd & s2_vd;
  assign hd_fall = ~s1_hd & s2_hd;

  // State, counters and all registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= SEEK;
      x          <= '0;
      y          <= '0;
      last_w     <= '0;
      err_frame  <= 1'b0;
      PIX_VALID  <= 1'b0;
      PIX_X      <= '0;
      PIX_Y      <= '0;
      PIX_RGB    <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_W    <= '0;
      FRAME_H    <= '0;
      LINE_ERR   <= 1'b0;
      SYNC_LOCK  <= 1'b0;
    end else begin
      state      <= state_nx;
      x          <= x_nx;
      y          <= y_nx;
      last_w     <= last_w_nx;
      err_frame  <= err_frame_nx;
      PIX_VALID  <= pix_valid_nx;
      PIX_X      <= pix_x_nx;
      PIX_Y      <= pix_y_nx;
      PIX_RGB    <= pix_rgb_nx;
      FRAME_DONE <= frame_done_nx;
      FRAME_W    <= frame_w_nx;
      FRAME_H    <= frame_h_nx;
      LINE_ERR   <= line_err_nx;
      SYNC_LOCK  <= sync_lock_nx;
    end
  end

  // Next-state and datapath. The DEN tick that opens a line captures pixel 0,
  // so a line of N enabled ticks reports width N. A VD fall inside a line
  // closes the line first, then the frame, without emitting that tick's pixel.
  always_comb begin
    state_nx      = state;
    x_nx          = x;
    y_nx          = y;
    last_w_nx     = last_w;
    err_frame_nx  = err_frame;
    line_err_nx   = LINE_ERR;
    pix_valid_nx  = 1'b0;
    pix_x_nx      = PIX_X;
    pix_y_nx      = PIX_Y;
    pix_rgb_nx    = PIX_RGB;
    frame_done_nx = 1'b0;
    frame_w_nx    = FRAME_W;
    frame_h_nx    = FRAME_H;
    sync_lock_nx  = SYNC_LOCK;
    cap           = 1'b0;
    close_line    = 1'b0;
    close_frame   = 1'b0;
    err_hit       = 1'b0;
    cap_x         = x;
    y_line        = (y == Y_MAX) ? Y_MAX : y + 10'd1;

    if (tick) begin
      case (state)
        SEEK: begin
          if (vd_fall) begin
            state_nx = LINE_WAIT;
            y_nx     = '0;
          end
        end
        LINE_WAIT: begin
          if (vd_fall) begin
            close_frame = 1'b1;
          end else if (s1_den) begin
            state_nx = LINE_ACT;
            cap      = 1'b1;
            cap_x    = '0;
          end
        end
        LINE_ACT: begin
          if (hd_fall)
            err_hit = 1'b1;
          if (vd_fall || !s1_den)
            close_line = 1'b1;
          if (vd_fall)
            close_frame = 1'b1;
          else if (s1_den)
            cap = 1'b1;
        end
        default: state_nx = SEEK;
      endcase
    end

    if (cap) begin
      pix_valid_nx = 1'b1;
      pix_x_nx     = cap_x;
      pix_y_nx     = y;
      pix_rgb_nx   = s1_rgb;
      if (cap_x == X_MAX)
        err_hit = 1'b1;
      else
        x_nx = cap_x + 11'd1;
    end

    if (close_line) begin
      if (y == Y_MAX)
        err_hit = 1'b1;
      if (x != H_ACT_W)
        err_hit = 1'b1;
      last_w_nx = x;
      y_nx      = y_line;
      state_nx  = LINE_WAIT;
    end

    if (close_frame) begin
      frame_w_nx    = close_line ? x : last_w;
      frame_h_nx    = close_line ? y_line : y;
      sync_lock_nx  = (frame_h_nx == V_ACT_H) && !(err_frame || err_hit);
      err_frame_nx  = 1'b0;
      y_nx          = '0;
      frame_done_nx = 1'b1;
      state_nx      = LINE_WAIT;
    end else begin
      err_frame_nx = err_frame | err_hit;
    end

    line_err_nx = LINE_ERR | err_hit;
  end

`ifdef LCD_RX_CAPTURE_SUM_EN
  logic [15:0] acc, acc_nx, frame_sum_nx;

  // Running colour sum of emitted pixels, published and restarted at frame close.
  always_comb begin
    acc_nx       = acc;
    frame_sum_nx = FRAME_SUM;
    if (cap)
      acc_nx = acc + {8'h00, s1_rgb[23:16]} + {8'h00, s1_rgb[15:8]} + {8'h00, s1_rgb[7:0]};
    if (close_frame) begin
      frame_sum_nx = acc;
      acc_nx       = '0;
    end
  end

  // Accumulator and published frame sum.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc       <= '0;
      FRAME_SUM <= '0;
    end else begin
      acc       <= acc_nx;
      FRAME_SUM <= frame_sum_nx;
    end
  end
`else
  // Default build carries no colour accumulator.
`endif

endmodule

// File: tb/tb_lcd_rx_capture.sv
// Bench for lcd_rx_capture. The reference model works at line/frame level:
// each driven line appends its expected pixels to a queue, and each VD fall
// appends the expected frame record. Frame geometry is reduced so that
// whole-frame scenarios stay short; define LCD_RX_CAPTURE_SUM_EN to also
// exercise FRAME_SUM.

module tb_lcd_rx_capture;

  localparam int TB_H = 128;
  localparam int TB_V = 12;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        NCLK = 1'b0, HD = 1'b1, VD = 1'b1, DEN = 1'b0;
  logic [7:0]  R = 8'h0, G = 8'h0, B = 8'h0;
  logic        PIX_VALID, FRAME_DONE, LINE_ERR, SYNC_LOCK;
  logic [10:0] PIX_X, FRAME_W;
  logic [9:0]  PIX_Y, FRAME_H;
  logic [23:0] PIX_RGB;
`ifdef LCD_RX_CAPTURE_SUM_EN
  logic [15:0] FRAME_SUM;
  logic        s_pix_valid, s_frame_done, s_line_err, s_sync_lock;
  logic [10:0] s_pix_x, s_frame_w;
  logic [9:0]  s_pix_y, s_frame_h;
  logic [23:0] s_pix_rgb;
  logic [15:0] s_frame_sum;
`endif

  int checks = 0;
  int errors = 0;

  logic [44:0] exp_pix[$], obs_pix[$];
  logic [37:0] exp_frm[$], obs_frm[$];

  bit          m_in_frame = 0;
  bit          m_err_frame = 0;
  bit          m_line_err = 0;
  int          m_y = 0;
  int          m_last_w = 0;
  logic [15:0] m_sum = 16'h0;

  always #5 CLK = ~CLK;

  lcd_rx_capture #(.H_ACT(TB_H), .V_ACT(TB_V)) dut (
    .CLK(CLK), .RST(RST), .NCLK(NCLK), .HD(HD), .VD(VD), .DEN(DEN),
    .R(R), .G(G), .B(B),
    .PIX_VALID(PIX_VALID), .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_RGB(PIX_RGB),
    .FRAME_DONE(FRAME_DONE), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H),
    .LINE_ERR(LINE_ERR), .SYNC_LOCK(SYNC_LOCK)
`ifdef LCD_RX_CAPTURE_SUM_EN
    , .FRAME_SUM(FRAME_SUM)
`endif
  );

`ifdef LCD_RX_CAPTURE_SUM_EN
  lcd_rx_capture #(.H_ACT(2), .V_ACT(2)) dut_s (
    .CLK(CLK), .RST(RST), .NCLK(NCLK), .HD(HD), .VD(VD), .DEN(DEN),
    .R(R), .G(G), .B(B),
    .PIX_VALID(s_pix_valid), .PIX_X(s_pix_x), .PIX_Y(s_pix_y), .PIX_RGB(s_pix_rgb),
    .FRAME_DONE(s_frame_done), .FRAME_W(s_frame_w), .FRAME_H(s_frame_h),
    .LINE_ERR(s_line_err), .SYNC_LOCK(s_sync_lock), .FRAME_SUM(s_frame_sum)
  );
`endif

  // Observed pulses, sampled on the falling edge.
  always @(negedge CLK) begin
    if (!RST) begin
      if (PIX_VALID)
        obs_pix.push_back({PIX_X, PIX_Y, PIX_RGB});
      if (FRAME_DONE)
`ifdef LCD_RX_CAPTURE_SUM_EN
        obs_frm.push_back({FRAME_W, FRAME_H, SYNC_LOCK, FRAME_SUM});
`else
        obs_frm.push_back({FRAME_W, FRAME_H, SYNC_LOCK, 16'h0});
`endif
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One LCD pixel clock (NCLK = CLK/2); bus changes together with NCLK rising.
  task automatic pclk(input logic hd, input logic vd, input logic den, input logic [23:0] rgb);
    @(negedge CLK);
    NCLK = 1'b1; HD = hd; VD = vd; DEN = den; {R, G, B} = rgb;
    @(negedge CLK);
    NCLK = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge CLK);
  endtask

  task automatic clear_q();
    exp_pix.delete(); obs_pix.delete(); exp_frm.delete(); obs_frm.delete();
  endtask

  function automatic logic [15:0] rgb_sum(input logic [23:0] c);
    return 16'(c[23:16]) + 16'(c[15:8]) + 16'(c[7:0]);
  endfunction

  function automatic int pix_bad();
    int n = 0;
    for (int i = 0; i < obs_pix.size() && i < exp_pix.size(); i++)
      if (obs_pix[i] !== exp_pix[i]) n++;
    if (obs_pix.size() > exp_pix.size()) n += obs_pix.size() - exp_pix.size();
    else n += exp_pix.size() - obs_pix.size();
    return n;
  endfunction

  function automatic logic [37:0] first_frm();
    return (obs_frm.size() > 0) ? obs_frm[0] : '1;
  endfunction

  // Model: a line of width w just ended inside a frame.
  task automatic model_line_closed(input int w);
    if (w != TB_H) begin
      m_err_frame = 1;
      m_line_err  = 1;
    end
    m_last_w = w;
    m_y++;
  endtask

  // Model: a VD fall; closes the open frame (if any) and opens the next one.
  task automatic model_vd_fall();
    logic lk;
    logic [15:0] s;
    if (m_in_frame) begin
      lk = (m_y == TB_V) && !m_err_frame;
`ifdef LCD_RX_CAPTURE_SUM_EN
      s = m_sum;
`else
      s = 16'h0;
`endif
      exp_frm.push_back({11'(m_last_w), 10'(m_y), lk, s});
    end
    m_y = 0; m_err_frame = 0; m_sum = 16'h0; m_in_frame = 1;
  endtask

  task automatic vsync();
    pclk(1'b1, 1'b0, 1'b0, 24'h0);
    model_vd_fall();
    pclk(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  // HSYNC, porch, w enabled pixels, then either DEN low or (abort) VD falling
  // while DEN is still high.
  task automatic send_line(input int w, input bit rnd, input logic [23:0] rgbc, input bit abort);
    logic [23:0] c;
    pclk(1'b0, 1'b1, 1'b0, 24'h0);
    pclk(1'b1, 1'b1, 1'b0, 24'h0);
    repeat ($urandom_range(0, 2)) pclk(1'b1, 1'b1, 1'b0, 24'h0);
    for (int i = 0; i < w; i++) begin
      c = rnd ? 24'($urandom) : rgbc;
      pclk(1'b1, 1'b1, 1'b1, c);
      if (m_in_frame) begin
        exp_pix.push_back({11'(i), 10'(m_y), c});
        m_sum += rgb_sum(c);
      end
    end
    if (abort) begin
      pclk(1'b1, 1'b0, 1'b1, 24'($urandom));
      if (m_in_frame) model_line_closed(w);
      model_vd_fall();
    end else begin
      pclk(1'b1, 1'b1, 1'b0, 24'h0);
      if (m_in_frame) model_line_closed(w);
    end
    pclk(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++; if (PIX_VALID !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got %0d want 0", PIX_VALID); end
    checks++; if (PIX_X !== 11'd0) begin errors++; $display("FAIL reset_pix_x got %0d want 0", PIX_X); end
    checks++; if (PIX_Y !== 10'd0) begin errors++; $display("FAIL reset_pix_y got %0d want 0", PIX_Y); end
    checks++; if (PIX_RGB !== 24'd0) begin errors++; $display("FAIL reset_pix_rgb got %h want 0", PIX_RGB); end
    checks++; if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0d want 0", FRAME_DONE); end
    checks++; if (FRAME_W !== 11'd0) begin errors++; $display("FAIL reset_frame_w got %0d want 0", FRAME_W); end
    checks++; if (FRAME_H !== 10'd0) begin errors++; $display("FAIL reset_frame_h got %0d want 0", FRAME_H); end
    checks++; if (LINE_ERR !== 1'b0) begin errors++; $display("FAIL reset_line_err got %0d want 0", LINE_ERR); end
    checks++; if (SYNC_LOCK !== 1'b0) begin errors++; $display("FAIL reset_sync_lock got %0d want 0", SYNC_LOCK); end
    RST = 1'b0;
    settle();
  endtask

  task automatic test_pre_vd_den();
    for (int l = 0; l < 3; l++) send_line($urandom_range(5, 20), 1, 24'h0, 0);
    settle();
    checks++; if (obs_pix.size() != 0) begin errors++; $display("FAIL pre_vd_pixels got %0d want 0", obs_pix.size()); end
    checks++; if (obs_frm.size() != 0) begin errors++; $display("FAIL pre_vd_frames got %0d want 0", obs_frm.size()); end
    clear_q();
  endtask

  task automatic test_full_frame();
    logic [37:0] f;
    vsync();
    for (int l = 0; l < TB_V; l++) send_line(TB_H, 0, 24'h303030, 0);
    vsync();
    settle();
    f = first_frm();
    checks++; if (obs_pix.size() != TB_H * TB_V) begin errors++; $display("FAIL full_pix_count got %0d want %0d", obs_pix.size(), TB_H * TB_V); end
    checks++; if (pix_bad() != 0) begin errors++; $display("FAIL full_pix_stream got %0d bad want 0", pix_bad()); end
    checks++; if (obs_frm.size() != 1) begin errors++; $display("FAIL full_frame_done got %0d want 1", obs_frm.size()); end
    checks++; if (f[37:27] !== 11'(TB_H)) begin errors++; $display("FAIL full_frame_w got %0d want %0d", f[37:27], TB_H); end
    checks++; if (f[26:17] !== 10'(TB_V)) begin errors++; $display("FAIL full_frame_h got %0d want %0d", f[26:17], TB_V); end
    checks++; if (f[16] !== 1'b1) begin errors++; $display("FAIL full_sync_lock got %0d want 1", f[16]); end
    checks++; if (LINE_ERR !== 1'b0) begin errors++; $display("FAIL full_line_err got %0d want 0", LINE_ERR); end
    clear_q();
  endtask

  task automatic test_random_frames();
    for (int fr = 0; fr < 2; fr++) begin
      for (int l = 0; l < TB_V; l++) send_line(TB_H, 1, 24'h0, 0);
      vsync();
      settle();
      checks++; if (pix_bad() != 0) begin errors++; $display("FAIL rand_pix_stream got %0d bad want 0", pix_bad()); end
      checks++; if (obs_frm.size() != exp_frm.size() || first_frm() !== exp_frm[0])
        begin errors++; $display("FAIL rand_frame got %h want %h", first_frm(), exp_frm[0]); end
      checks++; if (first_frm() >> 16 & 1 !== 1) begin errors++; $display("FAIL rand_sync_lock got %h want lock", first_frm()); end
      checks++; if (LINE_ERR !== m_line_err) begin errors++; $display("FAIL rand_line_err got %0d want %0d", LINE_ERR, m_line_err); end
      clear_q();
    end
  endtask

  task automatic test_short_line();
    int r;
    r = $urandom_range(0, TB_V - 1);
    for (int l = 0; l < TB_V; l++) send_line((l == r) ? TB_H - 1 : TB_H, 1, 24'h0, 0);
    vsync();
    settle();
    checks++; if (first_frm() !== exp_frm[0]) begin errors++; $display("FAIL short_frame got %h want %h", first_frm(), exp_frm[0]); end
    checks++; if (first_frm() >> 16 & 1 !== 0) begin errors++; $display("FAIL short_sync_lock got %h want no lock", first_frm()); end
    checks++; if (LINE_ERR !== 1'b1) begin errors++; $display("FAIL short_line_err got %0d want 1", LINE_ERR); end
    checks++; if (pix_bad() != 0) begin errors++; $display("FAIL short_pix_stream got %0d bad want 0", pix_bad()); end
    clear_q();
    for (int l = 0; l < TB_V; l++) send_line(TB_H, 1, 24'h0, 0);
    vsync();
    settle();
    checks++; if (first_frm() !== exp_frm[0]) begin errors++; $display("FAIL clean_frame got %h want %h", first_frm(), exp_frm[0]); end
    checks++; if (first_frm() >> 16 & 1 !== 1) begin errors++; $display("FAIL clean_sync_lock got %h want lock", first_frm()); end
    checks++; if (LINE_ERR !== 1'b1) begin errors++; $display("FAIL clean_line_err_sticky got %0d want 1", LINE_ERR); end
    clear_q();
  endtask

  task automatic test_vd_mid_line();
    int k;
    logic [37:0] f;
    k = $urandom_range(2, TB_V - 2);
    for (int l = 0; l < k; l++) send_line(TB_H, 1, 24'h0, 0);
    send_line(100, 1, 24'h0, 1);
    settle();
    f = first_frm();
    checks++; if (obs_frm.size() != 1) begin errors++; $display("FAIL mid_frame_done got %0d want 1", obs_frm.size()); end
    checks++; if (f[37:27] !== 11'd100) begin errors++; $display("FAIL mid_frame_w got %0d want 100", f[37:27]); end
    checks++; if (f[26:17] !== 10'(k + 1)) begin errors++; $display("FAIL mid_frame_h got %0d want %0d", f[26:17], k + 1); end
    checks++; if (f !== exp_frm[0]) begin errors++; $display("FAIL mid_frame got %h want %h", f, exp_frm[0]); end
    checks++; if (pix_bad() != 0) begin errors++; $display("FAIL mid_pix_stream got %0d bad want 0", pix_bad()); end
    clear_q();
  endtask

  task automatic test_reset_mid_frame();
    for (int l = 0; l < 10; l++) send_line(TB_H, 1, 24'h0, 0);
    pclk(1'b0, 1'b1, 1'b0, 24'h0);
    pclk(1'b1, 1'b1, 1'b0, 24'h0);
    for (int i = 0; i < 50; i++) pclk(1'b1, 1'b1, 1'b1, 24'($urandom));
    @(negedge CLK);
    NCLK = 1'b1;
    RST = 1'b1;
    @(negedge CLK);
    checks++; if ({PIX_VALID, PIX_X, PIX_Y, PIX_RGB, FRAME_DONE, FRAME_W, FRAME_H, LINE_ERR, SYNC_LOCK} !== '0)
      begin errors++; $display("FAIL midrst_outputs got v%0d x%0d y%0d err%0d lock%0d want all 0", PIX_VALID, PIX_X, PIX_Y, LINE_ERR, SYNC_LOCK); end
    clear_q();
    m_in_frame = 0; m_err_frame = 0; m_line_err = 0; m_y = 0; m_sum = 16'h0;
    NCLK = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 30; i++) pclk(1'b1, 1'b1, 1'b1, 24'($urandom));
    pclk(1'b1, 1'b1, 1'b0, 24'h0);
    for (int l = 0; l < 2; l++) send_line(TB_H, 1, 24'h0, 0);
    settle();
    checks++; if (obs_pix.size() != 0) begin errors++; $display("FAIL midrst_no_pixels got %0d want 0", obs_pix.size()); end
    checks++; if (obs_frm.size() != 0) begin errors++; $display("FAIL midrst_no_frames got %0d want 0", obs_frm.size()); end
    vsync();
    for (int l = 0; l < TB_V; l++) send_line(TB_H, 1, 24'h0, 0);
    vsync();
    settle();
    checks++; if (pix_bad() != 0) begin errors++; $display("FAIL midrst_pix_stream got %0d bad want 0", pix_bad()); end
    checks++; if (obs_frm.size() != 1 || first_frm() !== exp_frm[0])
      begin errors++; $display("FAIL midrst_frame got %h want %h", first_frm(), exp_frm[0]); end
    checks++; if (LINE_ERR !== 1'b0) begin errors++; $display("FAIL midrst_line_err got %0d want 0", LINE_ERR); end
    clear_q();
  endtask

`ifdef LCD_RX_CAPTURE_SUM_EN
  task automatic test_frame_sum();
    vsync();
    for (int l = 0; l < 2; l++) send_line(2, 0, 24'h010203, 0);
    vsync();
    settle();
    checks++; if (s_frame_sum !== 16'd24) begin errors++; $display("FAIL sum_value got %0d want 24", s_frame_sum); end
    checks++; if (s_frame_w !== 11'd2 || s_frame_h !== 10'd2) begin errors++; $display("FAIL sum_geometry got %0dx%0d want 2x2", s_frame_w, s_frame_h); end
    checks++; if (s_sync_lock !== 1'b1) begin errors++; $display("FAIL sum_sync_lock got %0d want 1", s_sync_lock); end
    clear_q();
  endtask
`endif

  initial begin
    test_reset();
    test_pre_vd_den();
    test_full_frame();
    test_random_frames();
    test_short_line();
    test_vd_mid_line();
    test_reset_mid_frame();
`ifdef LCD_RX_CAPTURE_SUM_EN
    test_frame_sum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
